// File: rtl/fetch_pkg.sv
// Shared fetch-path types and widths used by program_counter, fetch_queue and decode.
package fetch_pkg;

  localparam int ADDR_W   = 32;
  localparam int INSTR_W  = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping FIFO pointer: synchronous active-low reset, synchronous clear, increment enable.
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Width equals log2(DEPTH), so the +1 wraps DEPTH-1 back to 0 for free.
  always_ff @(posedge clk) begin
    if (!rst)     ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between program_counter and decode; flush drops wrong-path entries.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH   = fetch_pkg::FQ_DEPTH,
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instr,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic               flush,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [CW-1:0]      count
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q;
  logic            empty, byp, wr_en, rd_en;
  entry_t          head;

  assign empty       = (count_q == '0);
  assign fetch_ready = (count_q != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && fetch_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed pair that decode takes this cycle never touches storage.
  assign wr_en = fetch_valid && fetch_ready && !flush && !(byp && dec_ready);
  assign rd_en = dec_ready && !empty && !flush;

  assign head      = mem[rd_ptr];
  assign dec_valid = !empty || byp;
  assign dec_pc    = byp ? address : head.pc;
  assign dec_instr = byp ? instr   : head.instr;
  assign count     = count_q;

  fq_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_en),
    .ptr (rd_ptr)
  );

  fq_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_en),
    .ptr (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst)       count_q <= '0;
    else if (flush) count_q <= '0;
    else            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
  end

  // Storage is deliberately left out of reset; only occupancy defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pc: address, instr: instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps plus random traffic vs a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, flush, dec_valid, dec_ready;
  logic [31:0] address, instr, dec_pc, dec_instr;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [63:0] q[$];

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .instr       (instr),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model before the edge, advance the model.
  task automatic step(input logic r, input logic fl, input logic fv,
                      input logic [31:0] a, input logic [31:0] i, input logic dr);
    int          n;
    logic        e_fr, e_byp, e_dv;
    logic [63:0] e_head;
    rst = r; flush = fl; fetch_valid = fv; address = a; instr = i; dec_ready = dr;
    #2;
    n      = q.size();
    e_fr   = (n != DEPTH);
    e_byp  = BYP && (n == 0) && fv && !fl;
    e_dv   = (n != 0) || e_byp;
    e_head = e_byp ? {a, i} : ((n != 0) ? q[0] : 64'h0);
    if (r) begin
      chk("count", 64'(count), 64'(n));
      chk("fetch_ready", 64'(fetch_ready), 64'(e_fr));
      chk("dec_valid", 64'(dec_valid), 64'(e_dv));
      if (e_dv) chk("dec_head", {dec_pc, dec_instr}, e_head);
    end
    @(posedge clk);
    if (!r || fl) q.delete();
    else if (!(e_byp && dr)) begin
      if (e_dv && dr) void'(q.pop_front());
      if (fv && e_fr) q.push_back({a, i});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    address = '0; instr = '0;

    // Reset for two cycles, then idle.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_dec_valid", 64'(dec_valid), 64'd0);
    chk("reset_fetch_ready", 64'(fetch_ready), 64'd1);

    // Fill to full; fifth push must be ignored.
    for (int k = 0; k < 4; k++) step(1, 0, 1, 32'(4 * k), 32'hA0 + 32'(k), 0);
    step(1, 0, 1, 32'h10, 32'hA4, 0);
    chk("full_count", 64'(count), 64'd4);

    // Drain in order.
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("drained_dec_valid", 64'(dec_valid), 64'd0);

    // Streaming push+pop, pointers wrap.
    for (int k = 0; k < 10; k++) step(1, 0, 1, 32'h1000 + 32'(4 * k), 32'hB0 + 32'(k), 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1);

    // Count 3, flush with a push, then a new push.
    for (int k = 0; k < 3; k++) step(1, 0, 1, 32'h80 + 32'(4 * k), 32'hC0 + 32'(k), 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    step(1, 1, 1, 32'h100, 32'hD0, 0);
    chk("post_flush_count", 64'(count), 64'd0);
    step(1, 0, 1, 32'h200, 32'hD1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("post_flush_pc", 64'(dec_pc), 64'h200);
    step(1, 0, 0, 0, 0, 1);

    // Empty queue, push with decode ready: bypass or one-cycle latency.
    step(1, 0, 1, 32'h40, 32'hE0, 1);
    step(1, 0, 0, 0, 0, 1);

    // Random traffic with occasional flush and reset.
    pc = 32'h4000;
    for (int k = 0; k < 400; k++) begin
      logic r, fl, fv, dr;
      r  = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 19) == 0);
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      step(r, fl, fv, pc, $urandom, dr);
      pc = pc + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
